sobel_frame_writer: RTL and testbench

Drain-side endpoint of the Sobel pipeline: pops edge-magnitude pixels from the Sobel output FIFO and writes one full frame, in raster order, into a frame memory write port. A frame starts on a `start` pulse, runs to exactly IMG_WIDTH×IMG_HEIGHT writes, and signals completion. It is the counterpart of the RGB frame loader that fills the RGB input FIFO.

---
 rtl/sobel_frame_writer_pkg.sv | 20 ++
 rtl/frame_addr_counter.sv | 68 ++++++
 rtl/sobel_frame_writer.sv | 130 +++++++++++++
 tb/tb_sobel_frame_writer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_frame_writer_pkg.sv
// Shared definitions for the Sobel frame endpoints: the frame FSM state type
// and the frame-size helpers used to size the pixel counters.
package sobel_frame_writer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } frame_state_e;

   function automatic int unsigned frame_pixels(input int unsigned w, input int unsigned h);
      return w * h;
   endfunction

   // Counter width able to hold the full pixel count (not just count-1).
   function automatic int unsigned frame_cnt_w(input int unsigned w, input int unsigned h);
      return $clog2(w * h + 1);
   endfunction

endpackage

// File: rtl/frame_addr_counter.sv
// Pop/write counters and the raster address generator for one frame; flags
// whether more pixels may be popped and which accept completes the frame.
module frame_addr_counter
   import sobel_frame_writer_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = 720,
   parameter int unsigned IMG_HEIGHT = 540,
   parameter int unsigned AWIDTH     = 20,
   parameter int unsigned BASE_ADDR  = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear_i,
   input  logic              pop_i,
   input  logic              accept_i,
   output logic [AWIDTH-1:0] addr_o,
   output logic              pop_avail_o,
   output logic              last_wr_o
);

   localparam int unsigned N  = frame_pixels(IMG_WIDTH, IMG_HEIGHT);
   localparam int unsigned CW = frame_cnt_w(IMG_WIDTH, IMG_HEIGHT);
   localparam logic [CW-1:0]     N_C    = CW'(N);
   localparam logic [CW-1:0]     LAST_C = CW'(N - 1);
   localparam logic [CW-1:0]     ONE_C  = CW'(1);
   localparam logic [AWIDTH-1:0] BASE_C = AWIDTH'(BASE_ADDR);
   localparam logic [AWIDTH-1:0] ONE_A  = AWIDTH'(1);

   logic [CW-1:0]     pop_cnt_q, pop_cnt_d;
   logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
   logic [AWIDTH-1:0] addr_q, addr_d;

   always_comb begin
      pop_cnt_d = pop_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      addr_d    = addr_q;
      if (clear_i) begin
         pop_cnt_d = '0;
         wr_cnt_d  = '0;
         addr_d    = BASE_C;
      end else begin
         if (pop_i) begin
            pop_cnt_d = pop_cnt_q + ONE_C;
            addr_d    = addr_q + ONE_A;
         end
         if (accept_i) begin
            wr_cnt_d = wr_cnt_q + ONE_C;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pop_cnt_q <= '0;
         wr_cnt_q  <= '0;
         addr_q    <= BASE_C;
      end else begin
         pop_cnt_q <= pop_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         addr_q    <= addr_d;
      end
   end

   assign addr_o      = addr_q;
   assign pop_avail_o = (pop_cnt_q < N_C);
   assign last_wr_o   = accept_i && (wr_cnt_q == LAST_C);

endmodule

// File: rtl/sobel_frame_writer.sv
// Drains the Sobel output FIFO into frame memory, one raster-order frame per start.
// Optional running pixel checksum output when FRAME_WRITER_CHECKSUM_EN is defined.
module sobel_frame_writer
   import sobel_frame_writer_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = 720,
   parameter int unsigned IMG_HEIGHT = 540,
   parameter int unsigned DWIDTH     = 8,
   parameter int unsigned AWIDTH     = 20,
   parameter int unsigned BASE_ADDR  = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              frame_done,
   output logic              fifo_in_rd_en,
   input  logic [DWIDTH-1:0] fifo_in_dout,
   input  logic              fifo_in_empty,
   output logic              mem_wr_en,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
`ifdef FRAME_WRITER_CHECKSUM_EN
   output logic [31:0]       checksum,
`endif
   input  logic              mem_ready
);

   frame_state_e      state_q, state_d;
   logic              wr_en_q, wr_en_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [DWIDTH-1:0] wdata_q, wdata_d;
   logic              start_acc, pop, accept, pop_avail, last_wr;
   logic [AWIDTH-1:0] next_addr;

   assign start_acc = (state_q == IDLE) && start;
   assign accept    = wr_en_q && mem_ready;
   // A pop may refill the output register in the same cycle its write is accepted.
   assign pop       = (state_q == RUN) && !fifo_in_empty && pop_avail && (!wr_en_q || mem_ready);

   frame_addr_counter #(
      .IMG_WIDTH  (IMG_WIDTH),
      .IMG_HEIGHT (IMG_HEIGHT),
      .AWIDTH     (AWIDTH),
      .BASE_ADDR  (BASE_ADDR)
   ) u_addr_cnt (
      .clock       (clock),
      .reset       (reset),
      .clear_i     (start_acc),
      .pop_i       (pop),
      .accept_i    (accept),
      .addr_o      (next_addr),
      .pop_avail_o (pop_avail),
      .last_wr_o   (last_wr)
   );

   always_comb begin
      state_d    = state_q;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN: begin
            busy = 1'b1;
            if (last_wr) state_d = DONE;
         end
         DONE: begin
            frame_done = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_en_d = wr_en_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (pop) begin
         wr_en_d = 1'b1;
         addr_d  = next_addr;
         wdata_d = fifo_in_dout;
      end else if (accept) begin
         wr_en_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         wr_en_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         wr_en_q <= wr_en_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign fifo_in_rd_en = pop;
   assign mem_wr_en     = wr_en_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;

`ifdef FRAME_WRITER_CHECKSUM_EN
   logic [31:0] cks_q, cks_d;

   always_comb begin
      cks_d = cks_q;
      if (start_acc) begin
         cks_d = '0;
      end else if (accept) begin
         cks_d = cks_q + 32'(wdata_q);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cks_q <= '0;
      end else begin
         cks_q <= cks_d;
      end
   end

   assign checksum = cks_q;
`endif

endmodule

// File: tb/tb_sobel_frame_writer.sv
// Directed bench for sobel_frame_writer on a 4x3 frame at base 0x100.
// Covers streaming, backpressure, FIFO starvation, ignored start, async reset, checksum.
module tb_sobel_frame_writer;

   localparam int unsigned W  = 4;
   localparam int unsigned H  = 3;
   localparam int unsigned DW = 8;
   localparam int unsigned AW = 20;
   localparam int unsigned BA = 'h100;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          busy, frame_done, fifo_in_rd_en, fifo_in_empty, mem_wr_en;
   logic [DW-1:0] fifo_in_dout, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic          mem_ready = 1'b1;
`ifdef FRAME_WRITER_CHECKSUM_EN
   logic [31:0]   checksum;
`endif

   sobel_frame_writer #(
      .IMG_WIDTH (W), .IMG_HEIGHT (H), .DWIDTH (DW), .AWIDTH (AW), .BASE_ADDR (BA)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .busy          (busy),
      .frame_done    (frame_done),
      .fifo_in_rd_en (fifo_in_rd_en),
      .fifo_in_dout  (fifo_in_dout),
      .fifo_in_empty (fifo_in_empty),
      .mem_wr_en     (mem_wr_en),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
`ifdef FRAME_WRITER_CHECKSUM_EN
      .checksum      (checksum),
`endif
      .mem_ready     (mem_ready)
   );

   always #5 clock = ~clock;

   // Show-ahead FIFO model
   logic [7:0]  fifo_mem [0:255];
   logic [15:0] wr_ptr = '0;
   logic [15:0] rd_ptr = '0;
   assign fifo_in_empty = (wr_ptr == rd_ptr);
   assign fifo_in_dout  = fifo_mem[rd_ptr[7:0]];

   int n_pop = 0;
   int cyc   = 0;
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (fifo_in_rd_en) begin
         rd_ptr <= rd_ptr + 16'd1;
         n_pop  <= n_pop + 1;
      end
   end

   // Write monitor, sampled mid-cycle
   logic [AW-1:0] wr_addr [0:255];
   logic [DW-1:0] wr_data [0:255];
   int            wr_cyc  [0:255];
   int            n_wr = 0, n_hi = 0, n_stall = 0, n_stallpop = 0, n_unstable = 0;
   logic          prev_stall = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [DW-1:0] prev_data = '0;
   always @(negedge clock) begin
      if (mem_wr_en && mem_ready) begin
         wr_addr[n_wr[7:0]] <= mem_addr;
         wr_data[n_wr[7:0]] <= mem_wdata;
         wr_cyc[n_wr[7:0]]  <= cyc;
         n_wr <= n_wr + 1;
      end
      if (mem_wr_en) n_hi <= n_hi + 1;
      if (mem_wr_en && !mem_ready) n_stall <= n_stall + 1;
      if (fifo_in_rd_en && mem_wr_en && !mem_ready) n_stallpop <= n_stallpop + 1;
      if (prev_stall && (!mem_wr_en || mem_addr != prev_addr || mem_wdata != prev_data))
         n_unstable <= n_unstable + 1;
      prev_stall <= mem_wr_en && !mem_ready;
      prev_addr  <= mem_addr;
      prev_data  <= mem_wdata;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic push(input logic [7:0] d);
      fifo_mem[wr_ptr[7:0]] = d;
      wr_ptr = wr_ptr + 16'd1;
   endtask

   task automatic do_start(output int t0);
      @(posedge clock);
      #1 start = 1'b1;
      t0 = cyc;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok, output int dc);
      ok = 1'b0;
      dc = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (frame_done) begin
            ok = 1'b1;
            dc = cyc;
            break;
         end
      end
   endtask

   task automatic chk_frame(input string tag, input int base, input logic [7:0] d0);
      chk({tag, "_nwr"}, 32'(n_wr - base), 32'd12);
      for (int i = 0; i < 12; i++) begin
         chk({tag, "_addr"}, 32'(wr_addr[8'(base + i)]), 32'(BA + i));
         chk({tag, "_data"}, 32'(wr_data[8'(base + i)]), 32'(d0 + 8'(i)));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   int  t0, dc, base, pop0, hi0, st0, sp0, un0, bad;
   bit  ok, stop;
   logic [7:0] exp_d;

   initial begin
      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_rd_en", 32'(fifo_in_rd_en), 32'd0);
      @(posedge clock);
      #1 reset = 1'b1;
      repeat (2) @(posedge clock);

      // 1: streaming frame, always-ready memory
      for (int i = 1; i <= 12; i++) push(8'(i));
      base = n_wr; pop0 = n_pop; hi0 = n_hi;
      do_start(t0);
      @(negedge clock);
      chk("t1_busy_rise", 32'(busy), 32'd1);
      wait_done(100, ok, dc);
      chk("t1_done_seen", 32'(ok), 32'd1);
      chk("t1_latency", 32'(dc - t0), 32'd14);
      chk("t1_busy_in_done", 32'(busy), 32'd0);
      chk_frame("t1", base, 8'h01);
      bad = 0;
      for (int i = 0; i < 12; i++) if (wr_cyc[8'(base + i)] != t0 + 2 + i) bad++;
      chk("t1_back_to_back", 32'(bad), 32'd0);
      chk("t1_pops", 32'(n_pop - pop0), 32'd12);
      chk("t1_wr_hi_cycles", 32'(n_hi - hi0), 32'd12);
      @(negedge clock);
      chk("t1_busy_after", 32'(busy), 32'd0);
      chk("t1_done_pulse", 32'(frame_done), 32'd0);

      // 2: memory ready toggling every cycle
      for (int i = 0; i < 12; i++) push(8'h21 + 8'(i));
      base = n_wr; st0 = n_stall; sp0 = n_stallpop; un0 = n_unstable;
      stop = 1'b0;
      fork
         begin
            while (!stop) begin
               @(posedge clock);
               #1 mem_ready = ~mem_ready;
            end
         end
      join_none
      do_start(t0);
      wait_done(200, ok, dc);
      stop = 1'b1;
      @(posedge clock);
      #2 mem_ready = 1'b1;
      chk("t2_done_seen", 32'(ok), 32'd1);
      chk_frame("t2", base, 8'h21);
      chk("t2_stalls_seen", 32'(n_stall - st0 > 0), 32'd1);
      chk("t2_pop_in_stall", 32'(n_stallpop - sp0), 32'd0);
      chk("t2_stable", 32'(n_unstable - un0), 32'd0);

      // 3: FIFO fed one pixel every third cycle
      base = n_wr; pop0 = n_pop; hi0 = n_hi;
      do_start(t0);
      fork
         begin
            for (int i = 0; i < 12; i++) begin
               repeat (3) @(posedge clock);
               #1 push(8'h31 + 8'(i));
            end
         end
         wait_done(200, ok, dc);
      join
      chk("t3_done_seen", 32'(ok), 32'd1);
      chk_frame("t3", base, 8'h31);
      chk("t3_pops", 32'(n_pop - pop0), 32'd12);
      chk("t3_wr_hi_cycles", 32'(n_hi - hi0), 32'd12);

      // 4: 14 pixels queued, second start mid-frame ignored
      for (int i = 1; i <= 14; i++) push(8'(i));
      base = n_wr;
      do_start(t0);
      repeat (4) @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      wait_done(100, ok, dc);
      chk("t4_done_seen", 32'(ok), 32'd1);
      chk("t4_latency", 32'(dc - t0), 32'd14);
      chk_frame("t4", base, 8'h01);
      @(negedge clock);
      chk("t4_fifo_left", 32'(wr_ptr - rd_ptr), 32'd2);
      chk("t4_idle_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 10; i++) push(8'h60 + 8'(i));
      base = n_wr;
      do_start(t0);
      wait_done(100, ok, dc);
      chk("t4b_done_seen", 32'(ok), 32'd1);
      chk("t4b_first_data", 32'(wr_data[8'(base)]), 32'h0D);
      chk("t4b_first_addr", 32'(wr_addr[8'(base)]), 32'h100);
      chk("t4b_second_data", 32'(wr_data[8'(base + 1)]), 32'h0E);
      chk("t4b_second_addr", 32'(wr_addr[8'(base + 1)]), 32'h101);
      chk("t4b_nwr", 32'(n_wr - base), 32'd12);

      // 5: asynchronous reset mid-frame, then restart
      for (int i = 0; i < 12; i++) push(8'h51 + 8'(i));
      base = n_wr;
      do_start(t0);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (n_wr - base >= 5) begin
            ok = 1'b1;
            break;
         end
      end
      chk("t5_reached_5", 32'(ok), 32'd1);
      #1 reset = 1'b0;
      #1;
      chk("t5_wr_en", 32'(mem_wr_en), 32'd0);
      chk("t5_addr", 32'(mem_addr), 32'd0);
      chk("t5_wdata", 32'(mem_wdata), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_done", 32'(frame_done), 32'd0);
      chk("t5_rd_en", 32'(fifo_in_rd_en), 32'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1;
      chk("t5_idle_after", 32'(busy), 32'd0);
      while (32'(wr_ptr - rd_ptr) < 12) push(8'h70 + 8'(wr_ptr - rd_ptr));
      exp_d = fifo_mem[rd_ptr[7:0]];
      base = n_wr;
      do_start(t0);
      wait_done(100, ok, dc);
      chk("t5_done_seen", 32'(ok), 32'd1);
      chk("t5_restart_addr", 32'(wr_addr[8'(base)]), 32'h100);
      chk("t5_restart_data", 32'(wr_data[8'(base)]), 32'(exp_d));
      chk("t5_last_addr", 32'(wr_addr[8'(base + 11)]), 32'h10B);
      chk("t5_nwr", 32'(n_wr - base), 32'd12);

`ifdef FRAME_WRITER_CHECKSUM_EN
      // 6: checksum of twelve 0xFF pixels
      @(negedge clock);
      for (int i = 0; i < 12; i++) push(8'hFF);
      do_start(t0);
      @(negedge clock);
      chk("t6_cleared", checksum, 32'd0);
      wait_done(100, ok, dc);
      chk("t6_done_seen", 32'(ok), 32'd1);
      chk("t6_checksum", checksum, 32'h0000_0BF4);
      repeat (3) @(negedge clock);
      chk("t6_checksum_hold", checksum, 32'h0000_0BF4);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
